// File: rtl/bot_irq_pkg.sv
// Shared constants for the bot update interrupt stage.
// Bot info word layout is {LocX, LocY, Sensors, BotInfo}, 8 bits each.
package bot_irq_pkg;

  localparam int INFO_W = 32;
  localparam int OVF_W  = 8;

  // Byte lanes within a bot info word
  localparam int LOCX_LSB = 24;
  localparam int LOCY_LSB = 16;
  localparam int SENS_LSB = 8;
  localparam int INFO_LSB = 0;

endpackage

// File: rtl/bot_update_irq_if.sv
// Register-side bundle between bot_update_irq and the Wishbone register block.
//
// Strobe semantics: int_ack and ovf_clr are single-cycle pulses. They are
// sampled on the rising edge of clk and have no ready/handshake. A strobe
// has effect only in the cycle it is high. The status side (snap_info,
// pending, ovf_cnt, irq) is always valid and comes straight from flops.
interface bot_update_irq_if #(
  parameter int N_BOTS = 2,
  parameter int INFO_W = bot_irq_pkg::INFO_W,
  parameter int OVF_W  = bot_irq_pkg::OVF_W
);

  logic [N_BOTS-1:0]        int_ack;
  logic [N_BOTS-1:0]        ovf_clr;
  logic [N_BOTS-1:0]        irq_en;
  logic [N_BOTS*INFO_W-1:0] snap_info;
  logic [N_BOTS-1:0]        pending;
  logic [N_BOTS*OVF_W-1:0]  ovf_cnt;
  logic                     irq;

  // Register block side
  modport master (
    output int_ack, ovf_clr, irq_en,
    input  snap_info, pending, ovf_cnt, irq
  );

  // Interrupt stage side
  modport slave (
    input  int_ack, ovf_clr, irq_en,
    output snap_info, pending, ovf_cnt, irq
  );

endinterface

// File: rtl/bot_irq_chan.sv
// One bot channel: rising-edge detect on the update level, pending flag,
// coherent snapshot of the bot info word and a saturating overrun counter.
// The overrun counter exists only when BOT_IRQ_OVF_CNT_EN is defined;
// otherwise cnt is tied to zero and clr is ignored.
module bot_irq_chan #(
  parameter int INFO_W = bot_irq_pkg::INFO_W,
  parameter int OVF_W  = bot_irq_pkg::OVF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd,
  input  logic [INFO_W-1:0] info,
  input  logic              ack,
  input  logic              clr,
  input  logic              en,
  output logic [INFO_W-1:0] snap,
  output logic              pend,
  output logic [OVF_W-1:0]  cnt,
  output logic              req
);

  logic upd_prev;
  logic rise;
  logic overrun;

  // upd_prev resets high so a level already high at reset release is ignored
  assign rise    = upd & ~upd_prev;
  // An ack in the same cycle frees the slot, so the event is not an overrun
  assign overrun = rise & pend & ~ack;
  assign req     = pend & en;

  // Edge history, pending flag and snapshot; an event beats a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_prev <= 1'b1;
      pend     <= 1'b0;
      snap     <= '0;
    end else begin
      upd_prev <= upd;
      if (rise) begin
        snap <= info;
        pend <= 1'b1;
      end else if (ack) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef BOT_IRQ_OVF_CNT_EN
  // Saturating overrun count; a clear coinciding with an overrun leaves 1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= overrun ? OVF_W'(1) : '0;
    end else if (overrun && (cnt != {OVF_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = clr ^ overrun;
  assign cnt        = '0;
`endif

endmodule

// File: rtl/bot_update_irq.sv
// Bot update event / interrupt stage (clk domain).
// Instantiates one bot_irq_chan per bot and ORs the enabled pending flags
// into a single registered interrupt toward the CPU.
// Optional macro: BOT_IRQ_OVF_CNT_EN enables the per-bot overrun counters.
module bot_update_irq #(
  parameter int N_BOTS = 2,
  parameter int INFO_W = bot_irq_pkg::INFO_W,
  parameter int OVF_W  = bot_irq_pkg::OVF_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BOTS-1:0]        upd_sysregs,
  input  logic [N_BOTS*INFO_W-1:0] bot_info,
  bot_update_irq_if.slave          bus
);

  import bot_irq_pkg::*;

  logic [N_BOTS-1:0]        pend_w;
  logic [N_BOTS-1:0]        req_w;
  logic [N_BOTS*INFO_W-1:0] snap_w;
  logic [N_BOTS*OVF_W-1:0]  cnt_w;
  logic                     irq_q;

  for (genvar i = 0; i < N_BOTS; i++) begin : g_chan
    bot_irq_chan #(
      .INFO_W (INFO_W),
      .OVF_W  (OVF_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .upd   (upd_sysregs[i]),
      .info  (bot_info[i*INFO_W +: INFO_W]),
      .ack   (bus.int_ack[i]),
      .clr   (bus.ovf_clr[i]),
      .en    (bus.irq_en[i]),
      .snap  (snap_w[i*INFO_W +: INFO_W]),
      .pend  (pend_w[i]),
      .cnt   (cnt_w[i*OVF_W +: OVF_W]),
      .req   (req_w[i])
    );
  end

  // Combined interrupt, one cycle behind pending
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |req_w;
    end
  end

  assign bus.snap_info = snap_w;
  assign bus.pending   = pend_w;
  assign bus.ovf_cnt   = cnt_w;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_bot_update_irq.sv
// Testbench for bot_update_irq: directed steps followed by a randomized
// phase, all checked against a per-bot event model kept in the bench.
module tb_bot_update_irq;

  import bot_irq_pkg::*;

  localparam int N  = 2;
  localparam int IW = INFO_W;
  localparam int OW = OVF_W;
  localparam int OVF_MAX = (1 << OW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  upd_sysregs;
  logic [N*IW-1:0] bot_info;

  always #5 clk = ~clk;

  bot_update_irq_if #(.N_BOTS(N), .INFO_W(IW), .OVF_W(OW)) bus ();

  bot_update_irq #(
    .N_BOTS (N),
    .INFO_W (IW),
    .OVF_W  (OW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .upd_sysregs (upd_sysregs),
    .bot_info    (bot_info),
    .bus         (bus.slave)
  );

  // ---------------- reference model ----------------
  logic [N-1:0]  m_prev;
  logic [N-1:0]  m_pend;
  logic [IW-1:0] m_snap [N];
  int            m_cnt  [N];
  logic          m_irq;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s pending[%0d]", tag, i), 32'(bus.pending[i]), 32'(m_pend[i]));
      chk($sformatf("%s snap[%0d]", tag, i), bus.snap_info[i*IW +: IW], m_snap[i]);
      chk($sformatf("%s ovf_cnt[%0d]", tag, i), 32'(bus.ovf_cnt[i*OW +: OW]), 32'(m_cnt[i]));
    end
    chk($sformatf("%s irq", tag), 32'(bus.irq), 32'(m_irq));
  endtask

  // One clock: model reacts to what the DUT sees at the edge, then compare
  task automatic tick(input string tag);
    logic [N-1:0] pend_old;
    bit ev, ovr;
    @(posedge clk);
    pend_old = m_pend;
    if (reset) begin
      m_prev = '1;
      m_pend = '0;
      m_irq  = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_snap[i] = '0;
        m_cnt[i]  = 0;
      end
    end else begin
      m_irq = |(pend_old & bus.irq_en);
      for (int i = 0; i < N; i++) begin
        ev  = upd_sysregs[i] && !m_prev[i];
        ovr = ev && pend_old[i] && !bus.int_ack[i];
        if (ev) begin
          m_snap[i] = bot_info[i*IW +: IW];
          m_pend[i] = 1'b1;
        end else if (bus.int_ack[i]) begin
          m_pend[i] = 1'b0;
        end
`ifdef BOT_IRQ_OVF_CNT_EN
        if (bus.ovf_clr[i]) m_cnt[i] = ovr ? 1 : 0;
        else if (ovr && m_cnt[i] < OVF_MAX) m_cnt[i] = m_cnt[i] + 1;
`endif
      end
      m_prev = upd_sysregs;
    end
    #1;
    check_all(tag);
  endtask

  // ---------------- driver tasks ----------------
  // Drop the bot's level for a cycle, then raise it with fresh info and the
  // given strobes applied in the rising cycle.
  task automatic rise(input int b, input logic [IW-1:0] info,
                      input logic [N-1:0] ack, input logic [N-1:0] clr, input string tag);
    upd_sysregs[b] = 1'b0;
    tick({tag, " low"});
    upd_sysregs[b] = 1'b1;
    bot_info[b*IW +: IW] = info;
    bus.int_ack = ack;
    bus.ovf_clr = clr;
    tick(tag);
    bus.int_ack = '0;
    bus.ovf_clr = '0;
  endtask

  function automatic int exp_cnt(input int enabled_val);
`ifdef BOT_IRQ_OVF_CNT_EN
    return enabled_val;
`else
    return 0 * enabled_val;
`endif
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    upd_sysregs = 2'b01;
    bot_info    = '0;
    bus.int_ack = '0;
    bus.ovf_clr = '0;
    bus.irq_en  = '0;
    m_prev = '1;
    m_pend = '0;
    m_irq  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_snap[i] = '0;
      m_cnt[i]  = 0;
    end

    // Reset with bot0 level already high
    repeat (3) tick("reset");
    reset = 1'b0;
    repeat (10) begin
      tick("held_high_no_event");
      chk("held_high pending", 32'(bus.pending), 32'h0);
      chk("held_high irq", 32'(bus.irq), 32'h0);
    end

    // First bot0 event and ack
    bus.irq_en = 2'b01;
    rise(0, 32'h1234_5601, '0, '0, "bot0_first");
    chk("bot0_first snap", bus.snap_info[31:0], 32'h1234_5601);
    chk("bot0_first pending", 32'(bus.pending), 32'h1);
    chk("bot0_first irq_latency", 32'(bus.irq), 32'h0);
    tick("bot0_irq");
    chk("bot0_irq irq", 32'(bus.irq), 32'h1);
    bus.int_ack = 2'b01;
    tick("bot0_ack");
    bus.int_ack = '0;
    chk("bot0_ack pending", 32'(bus.pending), 32'h0);
    tick("bot0_ack_irq");
    chk("bot0_ack irq", 32'(bus.irq), 32'h0);

    // Bot1: three rises without ack, then clear coincident with a fourth
    rise(1, $urandom, '0, '0, "bot1_r1");
    rise(1, $urandom, '0, '0, "bot1_r2");
    rise(1, 32'hAABB_CC02, '0, '0, "bot1_r3");
    chk("bot1_ovf2 cnt", 32'(bus.ovf_cnt[15:8]), 32'(exp_cnt(2)));
    chk("bot1_ovf2 snap", bus.snap_info[63:32], 32'hAABB_CC02);
    chk("bot1_ovf2 pending", 32'(bus.pending[1]), 32'h1);
    rise(1, $urandom, '0, 2'b10, "bot1_clr_rise");
    chk("bot1_clr_rise cnt", 32'(bus.ovf_cnt[15:8]), 32'(exp_cnt(1)));

    // Ack coincident with an event on bot0 while pending
    rise(0, $urandom, '0, '0, "bot0_pend");
    rise(0, 32'h0F0F_0F0F, 2'b01, '0, "bot0_ack_rise");
    chk("bot0_ack_rise snap", bus.snap_info[31:0], 32'h0F0F_0F0F);
    chk("bot0_ack_rise pending", 32'(bus.pending[0]), 32'h1);
    chk("bot0_ack_rise cnt", 32'(bus.ovf_cnt[7:0]), 32'h0);

    // Saturation of bot0 overrun counter
    for (int k = 0; k < 300; k++) rise(0, $urandom, '0, '0, "bot0_sat");
    chk("bot0_sat cnt", 32'(bus.ovf_cnt[7:0]), 32'(exp_cnt(OVF_MAX)));

    // Enable both, drop irq_en without touching pending
    bus.irq_en = 2'b11;
    tick("en_both");
    tick("en_both_irq");
    chk("en_both irq", 32'(bus.irq), 32'h1);
    bus.irq_en = 2'b00;
    tick("en_off");
    chk("en_off irq", 32'(bus.irq), 32'h0);
    chk("en_off pending", 32'(bus.pending), 32'h3);
    bus.irq_en = 2'b11;
    tick("en_on");

    // Reset mid-operation, then a fresh first event
    reset = 1'b1;
    upd_sysregs = 2'b00;
    tick("mid_reset");
    chk("mid_reset pending", 32'(bus.pending), 32'h0);
    chk("mid_reset irq", 32'(bus.irq), 32'h0);
    reset = 1'b0;
    tick("post_reset");
    rise(1, 32'h5566_7788, '0, '0, "post_reset_first");
    chk("post_reset_first snap", bus.snap_info[63:32], 32'h5566_7788);
    chk("post_reset_first cnt", 32'(bus.ovf_cnt[15:8]), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      upd_sysregs = N'($urandom);
      bot_info    = {$urandom, $urandom};
      bus.int_ack = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bus.ovf_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) bus.irq_en = N'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick("random");
    end
    reset = 1'b0;
    bus.int_ack = '0;
    bus.ovf_clr = '0;
    tick("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
